// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell walks the operands LSB first through a
// registered carry, with valid/ready handshakes on the operand and result sides.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic             carry_q, carry_d;
    logic             res_cout_q, res_cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_y;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_sh_shifted;

    full_adder u_fa (
        .x1  (a_sh_q[0]),
        .x2  (b_sh_q[0]),
        .cin (carry_q),
        .y   (fa_y),
        .cout(fa_cout)
    );

    // New sum bit enters at the MSB so the LSB-first stream ends up in place.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_sh_shifted = fa_y;
        end else begin : g_wn
            assign sum_sh_shifted = {fa_y, sum_sh_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        sum_sh_d   = sum_sh_q;
        res_sum_d  = res_sum_q;
        carry_d    = carry_q;
        res_cout_d = res_cout_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = cin;
                    cnt_d    = '0;
                    sum_sh_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sum_sh_d = sum_sh_shifted;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Result copy keeps sum/cout stable after DONE until the next completion.
                    res_sum_d  = sum_sh_shifted;
                    res_cout_d = fa_cout;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            sum_sh_q   <= '0;
            res_sum_q  <= '0;
            carry_q    <= 1'b0;
            res_cout_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            sum_sh_q   <= sum_sh_d;
            res_sum_q  <= res_sum_d;
            carry_q    <= carry_d;
            res_cout_q <= res_cout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = res_sum_q;
    assign cout      = res_cout_q;
endmodule

module full_adder (
    input  logic x1,
    input  logic x2,
    input  logic cin,
    output logic y,
    output logic cout
);
    assign y    = x1 ^ x2 ^ cin;
    assign cout = (x1 & x2) | (cin & (x1 ^ x2));
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: 8-bit instance with a result scoreboard, plus
// exhaustive 3-bit and 1-bit instances.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [7:0] a, b, sum;
    logic       in_valid3, in_ready3, out_valid3, out_ready3, cin3, cout3, busy3;
    logic [2:0] a3, b3, sum3;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
    logic [0:0] a1, b1, sum1;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );
    serial_adder_ctrl #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .a(a3), .b(b3), .cin(cin3), .out_valid(out_valid3), .out_ready(out_ready3),
        .sum(sum3), .cout(cout3), .busy(busy3)
    );
    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    typedef struct packed {
        logic [7:0] s;
        logic       co;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   last_acc = -1;
    bit   t5_mode = 1'b0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: accept timing, result latency, and scoreboard pops on the output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && in_valid && in_ready) begin
            if (t5_mode && last_acc >= 0) check("t5_interval", cyc + 1 - last_acc, 10);
            last_acc = cyc + 1;
            acc_cyc  = cyc + 1;
        end
        if (rst_n && out_valid && !prev_ov) check("latency", cyc - acc_cyc, 8);
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: result 0x%0h/%0b with nothing expected", sum, cout);
            end else begin
                e = sb_q.pop_front();
                check("sum", sum, e.s);
                check("cout", cout, e.co);
            end
        end
        prev_ov = out_valid;
    end

    task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [7:0] es, input logic eco);
        int n;
        @(posedge clk); #1;
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        sb_q.push_back(exp_t'({es, eco}));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    vec_t vecs[8];

    initial begin
        int         n;
        logic       seen;
        logic [7:0] va, vb;
        logic       vc;
        logic [8:0] e9;
        logic [6:0] v3;
        logic [3:0] e3;
        logic [2:0] v1;
        logic [1:0] e1;

        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
        in_valid3 = 1'b0; out_ready3 = 1'b1; a3 = '0; b3 = '0; cin3 = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        // T1/T2 table
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co);
            wait_drain();
        end

        // T3 backpressure with in_valid held high during RUN/DONE
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1);
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t3_reached_done", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            check("t3_out_valid", out_valid, 1);
            check("t3_sum", sum, 8'h00);
            check("t3_cout", cout, 1);
            check("t3_in_ready", in_ready, 0);
            check("t3_busy", busy, 1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t3_out_valid_low", out_valid, 0);
        check("t3_back_idle", in_ready, 1);
        wait_drain();

        // T4 reset abandoned mid-RUN
        send(8'h11, 8'h22, 1'b0, 8'h33, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("t4_in_ready_rst", in_ready, 0);
        sb_q.delete();
        @(negedge clk);
        check("t4_busy", busy, 0);
        check("t4_out_valid", out_valid, 0);
        check("t4_sum", sum, 0);
        check("t4_cout", cout, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("t4_no_valid", seen, 0);
        check("t4_in_ready", in_ready, 1);
        send(8'h3C, 8'h41, 1'b1, 8'h7E, 1'b0);
        wait_drain();

        // T5 in_valid held continuously
        @(posedge clk); #1;
        t5_mode = 1'b1;
        last_acc = -1;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            va = 8'($urandom); vb = 8'($urandom); vc = 1'($urandom);
            a = va; b = vb; cin = vc;
            e9 = {1'b0, va} + {1'b0, vb} + {8'b0, vc};
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 30) begin
                @(negedge clk);
                n++;
            end
            check("t5_accept", in_ready, 1);
            sb_q.push_back(exp_t'({e9[7:0], e9[8]}));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_drain();
        t5_mode = 1'b0;

        // T6 WIDTH=3 exhaustive
        for (int i = 0; i < 128; i++) begin
            v3 = 7'(i);
            @(posedge clk); #1;
            {a3, b3, cin3} = v3;
            in_valid3 = 1'b1;
            e3 = {1'b0, v3[6:4]} + {1'b0, v3[3:1]} + {3'b0, v3[0]};
            n = 0;
            @(negedge clk);
            while (!in_ready3 && n < 20) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk); #1;
            in_valid3 = 1'b0;
            n = 0;
            @(negedge clk);
            while (!out_valid3 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("w3_result", {out_valid3, cout3, sum3}, {1'b1, e3});
        end

        // T6 WIDTH=1 smoke
        for (int i = 0; i < 8; i++) begin
            v1 = 3'(i);
            @(posedge clk); #1;
            {a1, b1, cin1} = v1;
            in_valid1 = 1'b1;
            e1 = {1'b0, v1[2]} + {1'b0, v1[1]} + {1'b0, v1[0]};
            n = 0;
            @(negedge clk);
            while (!in_ready1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            n = 0;
            @(negedge clk);
            while (!out_valid1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("w1_result", {out_valid1, cout1, sum1}, {1'b1, e1});
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
